pipe_stage_buf: RTL and testbench
=================================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised inter-stage pipeline register with valid/ready handshake and a one-entry skid buffer.
//  Replaces the fixed-field, wen-gated stage registers between any two back-end stages (e.g. MM1->MM2).
//  Carries an opaque payload, an exception vector and a PC, and supports synchronous flush.
//  Reports occupancy and keeps a saturating downstream-stall counter.
// PARAMETERS
//  DATA_W        64  payload width (packed csr/mem/op fields), >=1
//  EXC_W         8   exception flag vector width (adef,sys,brk,ine,ale,int,ertn,...), >=1
//  PC_W          32  PC width
//  CNT_W         16  stall counter width
//  ZERO_ON_FLUSH 1   1: flush also zeroes main-entry payload/exc/pc; 0: payload held, only valid cleared
// PORTS
//  clk         in  1       clock, all state on rising edge
//  rst_n       in  1       asynchronous active-low reset
//  flush       in  1       synchronous kill of all held and incoming entries
//  in_valid    in  1       upstream entry valid
//  in_ready    out 1       buffer can accept (= !skid_valid)
//  in_data     in  DATA_W  upstream payload
//  in_exc      in  EXC_W   upstream exception flags
//  in_pc       in  PC_W    upstream PC
//  out_valid   out 1       main entry valid
//  out_ready   in  1       downstream accepts
//  out_data    out DATA_W  main-entry payload
//  out_exc     out EXC_W   main-entry exception flags
//  out_exc_any out 1       out_valid & |out_exc
//  out_pc      out PC_W    main-entry PC
//  occupancy   out 2       entries held: 0,1,2
//  stall_clr   in  1       synchronous clear of stall_cnt
//  stall_cnt   out CNT_W   cycles with out_valid & !out_ready, saturating
// BEHAVIOUR
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Reset (rst_n=0, async): state EMPTY, main/skid valid=0, all data/exc/pc regs=0, stall_cnt=0;
//    hence out_valid=0, in_ready=1, occupancy=0, out_exc_any=0, outputs all 0.
//  - States: EMPTY (occ 0), HALF (main valid), FULL (main+skid valid). No other encodings reachable.
//  - EMPTY: in_fire -> main<=in, HALF. Else stay.
//  - HALF: in_fire&out_fire -> main<=in, HALF; in_fire&!out_fire -> skid<=in, FULL;
//          !in_fire&out_fire -> EMPTY; neither -> hold.
//  - FULL: in_ready=0 (no accept); out_fire -> main<=skid, skid invalid, HALF; else hold.
//  - Latency: in_fire in cycle N -> out_valid in cycle N+1 (EMPTY or HALF with out_fire). Throughput 1/cycle.
//  - Ordering strictly FIFO; skid never bypasses main.
//  - out_data/out_exc/out_pc stable while out_valid & !out_ready.
//  - in_ready is a pure function of registers (no in->out combinational path); out_exc_any combinational from main regs.
//  - flush (highest priority over in_fire/out_fire): next state EMPTY, both valids 0;
//    an in_fire in the flush cycle is discarded; an out_fire in the flush cycle still completes downstream.
//    ZERO_ON_FLUSH=1: main and skid data/exc/pc <= 0; =0: data regs unchanged.
//  - stall_cnt: +1 each cycle out_valid & !out_ready, saturates at 2^CNT_W-1; stall_clr wins over increment
//    (->0); flush does not clear it.
//  - Async reset asserted mid-transfer drops all entries immediately; no partial state survives.
// TESTING
//  1 Reset: rst_n=0 mid-cycle with occ=2 -> out_valid=0, in_ready=1, occupancy=0, stall_cnt=0 immediately.
//  2 Streaming: out_ready=1, in_valid=1 with pc=0x1c000000,+4,+8 -> out_pc same sequence one cycle later,
//    occupancy=1 throughout, in_ready=1.
//  3 Backpressure: out_ready=0, push pc A=0x100,B=0x104 -> occ=2, in_ready=0, out_pc=0x100 held;
//    out_ready=1 -> 0x100 then 0x104 on consecutive cycles, occ 2->1->0.
//  4 Flush: occ=2 plus in_valid=1 in flush cycle -> next cycle occ=0, out_valid=0;
//    ZERO_ON_FLUSH=1 -> out_pc=0, out_data=0.
//  5 Exceptions: in_exc=8'h10 accepted -> out_exc=8'h10, out_exc_any=1; after drain out_exc_any=0.
//  6 Stall counter: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated);
//    stall_clr=1 -> 0 next cycle.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// -----------------------------------------------------------------------------
// pipe_stage_buf
//   Inter-stage pipeline register with a valid/ready handshake and a one-entry
//   skid buffer.  Each entry carries an opaque payload, an exception vector and
//   a PC.  Supports a synchronous flush, reports occupancy and keeps a
//   saturating count of downstream stall cycles.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   flush                  synchronous kill of held and incoming entries
//   in_valid / in_ready    upstream handshake (in_ready = skid slot free)
//   in_data/in_exc/in_pc   upstream entry
//   out_valid / out_ready  downstream handshake (out_valid = main entry valid)
//   out_data/out_exc/out_pc main entry contents
//   out_exc_any            out_valid & |out_exc
//   occupancy              entries held: 0, 1 or 2
//   stall_clr              synchronous clear of stall_cnt
//   stall_cnt              saturating count of out_valid & !out_ready cycles
// -----------------------------------------------------------------------------
module pipe_stage_buf #(
    parameter int DATA_W        = 64,
    parameter int EXC_W         = 8,
    parameter int PC_W          = 32,
    parameter int CNT_W         = 16,
    parameter int ZERO_ON_FLUSH = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_exc_any,
    output logic [PC_W-1:0]   out_pc,
    output logic [1:0]        occupancy,
    input  logic              stall_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;

    logic [DATA_W-1:0] main_data;
    logic [EXC_W-1:0]  main_exc;
    logic [PC_W-1:0]   main_pc;
    logic [DATA_W-1:0] skid_data;
    logic [EXC_W-1:0]  skid_exc;
    logic [PC_W-1:0]   skid_pc;

    logic              in_fire;
    logic              out_fire;
    logic              stall;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return v;
        else
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Handshake outputs depend only on registered state, so there is no
    // combinational path from in_valid/out_ready to in_ready/out_valid.
    assign out_valid   = (state != EMPTY);
    assign in_ready    = (state != FULL);
    assign occupancy   = state;
    assign out_data    = main_data;
    assign out_exc     = main_exc;
    assign out_pc      = main_pc;
    assign out_exc_any = out_valid & (|main_exc);

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;
    assign stall    = out_valid & ~out_ready;

    // ---- stage boundary: main / skid entry registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            main_data <= '0;
            main_exc  <= '0;
            main_pc   <= '0;
            skid_data <= '0;
            skid_exc  <= '0;
            skid_pc   <= '0;
        end else if (flush) begin
            // Flush outranks both handshakes: an incoming entry is dropped,
            // an outgoing one has already been sampled downstream this edge.
            state <= EMPTY;
            if (ZERO_ON_FLUSH != 0) begin
                main_data <= '0;
                main_exc  <= '0;
                main_pc   <= '0;
                skid_data <= '0;
                skid_exc  <= '0;
                skid_pc   <= '0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_data <= in_data;
                        main_exc  <= in_exc;
                        main_pc   <= in_pc;
                        state     <= HALF;
                    end
                end
                HALF: begin
                    if (in_fire && out_fire) begin
                        main_data <= in_data;
                        main_exc  <= in_exc;
                        main_pc   <= in_pc;
                    end else if (in_fire) begin
                        // Main is stalled: park the new entry behind it.
                        skid_data <= in_data;
                        skid_exc  <= in_exc;
                        skid_pc   <= in_pc;
                        state     <= FULL;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        main_data <= skid_data;
                        main_exc  <= skid_exc;
                        main_pc   <= skid_pc;
                        state     <= HALF;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // ---- stage boundary: stall counter ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_clr)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= sat_inc(stall_cnt);
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int DATA_W = 64;
    localparam int EXC_W  = 8;
    localparam int PC_W   = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [EXC_W-1:0]  in_exc;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [EXC_W-1:0]  out_exc;
    logic              out_exc_any;
    logic [PC_W-1:0]   out_pc;
    logic [1:0]        occupancy;
    logic              stall_clr;
    logic [CNT_W-1:0]  stall_cnt;

    int checks;
    int errors;

    pipe_stage_buf #(
        .DATA_W(DATA_W),
        .EXC_W(EXC_W),
        .PC_W(PC_W),
        .CNT_W(CNT_W),
        .ZERO_ON_FLUSH(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_exc(in_exc),
        .in_pc(in_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_exc(out_exc),
        .out_exc_any(out_exc_any),
        .out_pc(out_pc),
        .occupancy(occupancy),
        .stall_clr(stall_clr),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_exc    = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        stall_clr = 1'b0;

        // Reset state
        step();
        step();
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd1);
        chk("rst occupancy", 64'(occupancy), 64'd0);
        chk("rst stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst out_pc", 64'(out_pc), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst out_exc_any", 64'(out_exc_any), 64'd0);
        rst_n = 1'b1;
        step();

        // Streaming: one-cycle latency, occupancy 1, full throughput
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h1c00_0000;
        in_data   = 64'h1111;
        step();
        chk("stream pc0", 64'(out_pc), 64'h1c00_0000);
        chk("stream data0", out_data, 64'h1111);
        chk("stream occ0", 64'(occupancy), 64'd1);
        chk("stream rdy0", 64'(in_ready), 64'd1);
        in_pc   = 32'h1c00_0004;
        in_data = 64'h2222;
        step();
        chk("stream pc1", 64'(out_pc), 64'h1c00_0004);
        chk("stream occ1", 64'(occupancy), 64'd1);
        in_pc   = 32'h1c00_0008;
        in_data = 64'h3333;
        step();
        chk("stream pc2", 64'(out_pc), 64'h1c00_0008);
        chk("stream data2", out_data, 64'h3333);
        chk("stream occ2", 64'(occupancy), 64'd1);
        in_valid = 1'b0;
        step();
        chk("stream drained occ", 64'(occupancy), 64'd0);
        chk("stream drained vld", 64'(out_valid), 64'd0);
        chk("stream no stalls", 64'(stall_cnt), 64'd0);

        // Backpressure: skid fills, main held, FIFO drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h100;
        in_data   = 64'hA0;
        step();
        chk("bp occ after A", 64'(occupancy), 64'd1);
        in_pc   = 32'h104;
        in_data = 64'hB0;
        step();
        chk("bp occ full", 64'(occupancy), 64'd2);
        chk("bp in_ready low", 64'(in_ready), 64'd0);
        chk("bp hold pc A", 64'(out_pc), 64'h100);
        in_valid = 1'b0;
        step();
        chk("bp still pc A", 64'(out_pc), 64'h100);
        chk("bp still data A", out_data, 64'hA0);
        chk("bp stall count", 64'(stall_cnt), 64'd2);
        out_ready = 1'b1;
        step();
        chk("bp drain pc B", 64'(out_pc), 64'h104);
        chk("bp drain data B", out_data, 64'hB0);
        chk("bp occ 1", 64'(occupancy), 64'd1);
        chk("bp in_ready back", 64'(in_ready), 64'd1);
        step();
        chk("bp occ 0", 64'(occupancy), 64'd0);
        stall_clr = 1'b1;
        step();
        chk("bp stall cleared", 64'(stall_cnt), 64'd0);
        stall_clr = 1'b0;

        // Flush with full buffer and an incoming entry in the flush cycle
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h200;
        in_data   = 64'hAA;
        step();
        in_pc   = 32'h204;
        in_data = 64'hBB;
        step();
        chk("fl pre occ", 64'(occupancy), 64'd2);
        flush   = 1'b1;
        in_pc   = 32'h208;
        in_data = 64'hCC;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl occ", 64'(occupancy), 64'd0);
        chk("fl out_valid", 64'(out_valid), 64'd0);
        chk("fl out_pc zero", 64'(out_pc), 64'd0);
        chk("fl out_data zero", out_data, 64'd0);
        chk("fl in_ready", 64'(in_ready), 64'd1);
        chk("fl stall kept", 64'(stall_cnt), 64'd2);
        step();
        chk("fl stays empty", 64'(occupancy), 64'd0);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;

        // Async reset mid-cycle with two entries held
        in_valid = 1'b1;
        in_pc    = 32'h400;
        step();
        in_pc = 32'h404;
        step();
        in_valid = 1'b0;
        chk("ar pre occ", 64'(occupancy), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar out_valid", 64'(out_valid), 64'd0);
        chk("ar in_ready", 64'(in_ready), 64'd1);
        chk("ar occ", 64'(occupancy), 64'd0);
        chk("ar stall_cnt", 64'(stall_cnt), 64'd0);
        #1;
        rst_n = 1'b1;
        step();
        chk("ar post occ", 64'(occupancy), 64'd0);

        // Exceptions
        in_valid = 1'b1;
        in_exc   = 8'h10;
        in_pc    = 32'h300;
        step();
        chk("exc out_exc", 64'(out_exc), 64'h10);
        chk("exc any set", 64'(out_exc_any), 64'd1);
        in_valid  = 1'b0;
        in_exc    = '0;
        out_ready = 1'b1;
        step();
        chk("exc any cleared", 64'(out_exc_any), 64'd0);
        chk("exc drained occ", 64'(occupancy), 64'd0);

        // Stall counter saturation and clear priority
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_pc     = 32'h500;
        step();
        in_valid = 1'b0;
        chk("sc start", 64'(stall_cnt), 64'd0);
        for (int i = 0; i < 20; i++) step();
        chk("sc saturated", 64'(stall_cnt), 64'd15);
        stall_clr = 1'b1;
        step();
        chk("sc clr wins", 64'(stall_cnt), 64'd0);
        stall_clr = 1'b0;
        step();
        chk("sc resumes", 64'(stall_cnt), 64'd1);
        out_ready = 1'b1;
        step();
        chk("sc drained", 64'(occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
